dct_2d_8x8_stream: RTL and testbench
====================================

// Module: dct_2d_8x8_stream
// PURPOSE
//  Row-serial, handshaked 8x8 2-D DCT/IDCT engine computing Y = M*X*M^T.
//  Forward mode uses M = C. Inverse mode uses M = C^T.
//  One 8-sample row is accepted per beat. Row transform results go into an internal
//  transpose buffer; the column transform then drains 8 output rows with valid/ready.
//  Sits between the block splitter and the quantiser. Supersedes the fully parallel,
//  fixed-width 2-D DCT and adds rounding, saturation, backpressure and inverse mode.
// PARAMETERS
//  IN_WIDTH   16  signed input sample width
//  COEF_WIDTH 16  signed coefficient width
//  COEF_FRAC  12  fractional bits of coefficients (Q format)
//  MID_WIDTH  24  signed width of transpose-buffer entries (row-stage result)
//  OUT_WIDTH  24  signed output coefficient width
// PORTS
//  clk           in   1              rising-edge clock
//  reset_n       in   1              async active-low reset
//  clear         in   1              sync abort: discard block in progress
//  inverse       in   1              0=forward DCT, 1=IDCT; sampled on first row beat of a block
//  coeff_matrix  in   64*COEF_WIDTH  C[k][x] at index k*8+x; must be stable while busy
//  in_valid      in   1              in_data holds a valid row
//  in_ready      out  1              block can accept a row
//  in_data       in   8*IN_WIDTH     row samples; sample x at [x*IN_WIDTH +: IN_WIDTH]
//  out_valid     out  1              out_data holds a valid output row
//  out_ready     in   1              downstream accepts the row
//  out_data      out  8*OUT_WIDTH    output row u; element v at [v*OUT_WIDTH +: OUT_WIDTH]
//  out_last      out  1              high with out_valid on output row 7
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=FILL, row_cnt=0, out_cnt=0.
//   - in_ready=1, out_valid=0, out_last=0, out_data=0.
//   - Buffer contents are don't-care.
//  FILL state:
//   - in_ready=1.
//   - On in_valid&in_ready, buffer row row_cnt <= T[k] = rnd_sat_MID(sum_x M[k][x]*in[x]), k=0..7.
//   - row_cnt then increments.
//   - On row_cnt==0, inverse is latched for the whole block.
//   - The accept with row_cnt==7 moves to CALC, with row_cnt=0.
//  CALC state (1 cycle):
//   - in_ready=0.
//   - out_data <= Y[0][v] = rnd_sat_OUT(sum_r M[0][r]*T[r][v]).
//   - out_valid <= 1, out_cnt <= 1, state moves to DRAIN.
//  DRAIN state:
//   - out_valid=1; out_data and out_last are held stable until out_valid&out_ready.
//   - On handshake with out_cnt<8: load row out_cnt, then out_cnt++.
//   - On handshake with out_cnt==8: out_valid <= 0, state moves to FILL. No new row is accepted that cycle.
//  Latency:
//   - 8th input accepted at cycle T -> row 0 valid at T+2.
//   - With out_ready=1, rows 0..7 appear at T+2..T+9.
//   - Min block period is 17 cycles.
//  Arithmetic:
//   - Full-precision accumulation, no intermediate truncation.
//   - rnd = add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC (round half up).
//   - sat = clamp to [-2^(W-1), 2^(W-1)-1] of the target width.
//  clear:
//   - Highest priority sync event in every state.
//   - Next cycle: FILL, row_cnt=0, out_valid=0. Any handshake in the same cycle is ignored.
//  Simultaneous in_valid and clear: the row is dropped.
//  in_valid while not in FILL: ignored (in_ready=0). Data does not need to be held.
//  coeff_matrix changing while busy: result undefined (caller's responsibility).
// TESTING
//  - Identity C (C[k][k]=4096, else 0), rows X[r][x]=r*8+x, out_ready=1 -> Y==X, row 0 at T+2, out_last on 8th row only.
//  - Orthonormal DCT Q12 (c0=1448), all samples 100 -> Y[0][0]=800, all other |Y|<=1.
//  - Inverse=1, same C, input Y[0][0]=800 others 0 -> every output within 100+-1. A following block with inverse=0 is forward.
//  - Backpressure: out_ready pattern 1,0,0,1,0,1... -> out_data and out_last stable while stalled. Exactly 8 rows in order; in_ready=0 until the last row handshake.
//  - Identity C times 2 (8192), in=32767 and -32768 with OUT_WIDTH=MID_WIDTH=16 -> outputs saturate to 32767 and -32768, no wrap.
//  - clear after 3 rows, then a full block A -> output equals the transform of A only.
//  - reset_n pulse mid-DRAIN -> out_valid=0 immediately; the next block is correct.

Source files
------------

// File: rtl/dct_2d_8x8_stream_if.sv
// Row-stream bus of the 8x8 DCT engine: input row channel and output row channel.
//   in_valid/in_ready/in_data         one 8-sample row per handshake
//   out_valid/out_ready/out_data/out_last  one 8-coefficient output row per handshake
// master: the side that feeds rows and consumes results; slave: the transform engine.
interface dct_2d_8x8_stream_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic [8*IN_WIDTH-1:0]    in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic [8*OUT_WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dct_2d_8x8_stream.sv
// Row-serial 8x8 2-D DCT/IDCT: Y = M*X*M^T, M = C (forward) or C^T (inverse).
// Ports:
//   clk, reset_n   clock, async active-low reset
//   clear          sync abort of the block in progress (highest priority)
//   inverse        transform direction, captured on the first row of a block
//   coeff_matrix   C[k][x] at index k*8+x, COEF_WIDTH each, Q(COEF_FRAC)
//   bus (slave)    input row stream and output row stream (valid/ready)
module dct_2d_8x8_stream #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned COEF_FRAC  = 12,
  parameter int unsigned MID_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      inverse,
  input  logic [64*COEF_WIDTH-1:0]  coeff_matrix,
  dct_2d_8x8_stream_if.slave        bus
);

  localparam int unsigned ROW_PROD_W = IN_WIDTH + COEF_WIDTH;
  localparam int unsigned ROW_ACC_W  = ROW_PROD_W + 3;
  localparam int unsigned COL_PROD_W = MID_WIDTH + COEF_WIDTH;
  localparam int unsigned COL_ACC_W  = COL_PROD_W + 3;

  localparam logic signed [ROW_ACC_W-1:0] ROW_HALF = ROW_ACC_W'(64'sd1 <<< (COEF_FRAC - 1));
  localparam logic signed [ROW_ACC_W-1:0] MID_HI   = ROW_ACC_W'((64'sd1 <<< (MID_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ROW_ACC_W-1:0] MID_LO   = ~MID_HI;
  localparam logic signed [COL_ACC_W-1:0] COL_HALF = COL_ACC_W'(64'sd1 <<< (COEF_FRAC - 1));
  localparam logic signed [COL_ACC_W-1:0] OUT_HI   = COL_ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [COL_ACC_W-1:0] OUT_LO   = ~OUT_HI;

  typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               row_cnt_q, row_cnt_d;
  logic [3:0]               out_cnt_q, out_cnt_d;
  logic                     inv_q, inv_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [8*OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                     buf_we;

  logic signed [COEF_WIDTH-1:0] coef [64];
  logic signed [IN_WIDTH-1:0]   sample [8];
  logic signed [MID_WIDTH-1:0]  tbuf [8][8];
  logic signed [MID_WIDTH-1:0]  row_res [8];
  logic signed [ROW_ACC_W-1:0]  row_acc;
  logic signed [COL_ACC_W-1:0]  col_acc;
  logic [8*OUT_WIDTH-1:0]       col_row;
  logic                         row_inv;
  logic [2:0]                   col_u;

  // Element (k,x) of M: C[k][x] forward, C[x][k] inverse.
  function automatic logic [5:0] m_idx(input logic [2:0] k, input logic [2:0] x, input logic inv);
    return inv ? {x, k} : {k, x};
  endfunction

  // Round half up to integer, then clamp to the transpose-buffer width.
  function automatic logic signed [MID_WIDTH-1:0] rnd_sat_mid(input logic signed [ROW_ACC_W-1:0] acc);
    logic signed [ROW_ACC_W-1:0] r;
    r = (acc + ROW_HALF) >>> COEF_FRAC;
    if (r > MID_HI)      r = MID_HI;
    else if (r < MID_LO) r = MID_LO;
    return MID_WIDTH'(r);
  endfunction

  // Round half up to integer, then clamp to the output width.
  function automatic logic signed [OUT_WIDTH-1:0] rnd_sat_out(input logic signed [COL_ACC_W-1:0] acc);
    logic signed [COL_ACC_W-1:0] r;
    r = (acc + COL_HALF) >>> COEF_FRAC;
    if (r > OUT_HI)      r = OUT_HI;
    else if (r < OUT_LO) r = OUT_LO;
    return OUT_WIDTH'(r);
  endfunction

  // Unpack coefficient matrix and the incoming row.
  always_comb begin : unpack
    for (int i = 0; i < 64; i++) coef[i] = $signed(coeff_matrix[i*COEF_WIDTH +: COEF_WIDTH]);
    for (int x = 0; x < 8; x++) sample[x] = $signed(bus.in_data[x*IN_WIDTH +: IN_WIDTH]);
  end

  // The first row of a block uses the live direction input; later rows use the latched one.
  assign row_inv = (row_cnt_q == 3'd0) ? inverse : inv_q;

  // Row transform: T[k] = sum_x M[k][x] * in[x].
  always_comb begin : row_stage
    row_acc = '0;
    for (int k = 0; k < 8; k++) begin
      row_acc = '0;
      for (int x = 0; x < 8; x++)
        row_acc = row_acc + ROW_ACC_W'(ROW_PROD_W'(coef[m_idx(3'(k), 3'(x), row_inv)]) *
                                       ROW_PROD_W'(sample[x]));
      row_res[k] = rnd_sat_mid(row_acc);
    end
  end

  // CALC produces output row 0; DRAIN produces the row indexed by out_cnt.
  assign col_u = (state_q == CALC) ? 3'd0 : out_cnt_q[2:0];

  // Column transform for one output row: Y[u][v] = sum_r M[u][r] * T[r][v].
  always_comb begin : col_stage
    col_row = '0;
    col_acc = '0;
    for (int v = 0; v < 8; v++) begin
      col_acc = '0;
      for (int r = 0; r < 8; r++)
        col_acc = col_acc + COL_ACC_W'(COL_PROD_W'(coef[m_idx(col_u, 3'(r), inv_q)]) *
                                       COL_PROD_W'(tbuf[r][v]));
      col_row[v*OUT_WIDTH +: OUT_WIDTH] = rnd_sat_out(col_acc);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    out_cnt_d   = out_cnt_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    buf_we      = 1'b0;
    if (clear) begin
      state_d     = FILL;
      row_cnt_d   = '0;
      out_cnt_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.in_valid && in_ready_q) begin
            buf_we    = 1'b1;
            row_cnt_d = row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd0) inv_d   = inverse;
            if (row_cnt_q == 3'd7) state_d = CALC;
          end
        end
        CALC: begin
          out_data_d  = col_row;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_cnt_d   = 4'd1;
          state_d     = DRAIN;
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (out_cnt_q == 4'd8) begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              out_cnt_d   = '0;
              state_d     = FILL;
            end else begin
              out_data_d = col_row;
              out_last_d = (out_cnt_q == 4'd7);
              out_cnt_d  = out_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
    in_ready_d = (state_d == FILL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin : regs
    if (!reset_n) begin
      state_q     <= FILL;
      row_cnt_q   <= '0;
      out_cnt_q   <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Transpose buffer: contents are only meaningful within a block, so no reset.
  always_ff @(posedge clk) begin : tbuf_write
    if (buf_we)
      for (int k = 0; k < 8; k++) tbuf[row_cnt_q][k] <= row_res[k];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_dct_2d_8x8_stream.sv
// Bench for dct_2d_8x8_stream: two instances (24-bit and 16-bit mid/out widths) share one
// stimulus stream; results are compared against a matrix-level reference model.
module tb_dct_2d_8x8_stream;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 16;

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             inverse;
  logic             in_valid;
  logic             out_ready;
  logic [64*CW-1:0] coeff;
  logic [8*IW-1:0]  in_data;

  dct_2d_8x8_stream_if #(.IN_WIDTH(IW), .OUT_WIDTH(24)) bus ();
  dct_2d_8x8_stream_if #(.IN_WIDTH(IW), .OUT_WIDTH(16)) bus16 ();

  assign bus.in_valid    = in_valid;
  assign bus.in_data     = in_data;
  assign bus.out_ready   = out_ready;
  assign bus16.in_valid  = in_valid;
  assign bus16.in_data   = in_data;
  assign bus16.out_ready = out_ready;

  dct_2d_8x8_stream #(.IN_WIDTH(IW), .COEF_WIDTH(CW), .COEF_FRAC(12), .MID_WIDTH(24), .OUT_WIDTH(24)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .inverse(inverse), .coeff_matrix(coeff), .bus(bus)
  );

  dct_2d_8x8_stream #(.IN_WIDTH(IW), .COEF_WIDTH(CW), .COEF_FRAC(12), .MID_WIDTH(16), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .inverse(inverse), .coeff_matrix(coeff), .bus(bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks;
  int     errors;
  int     cm [64];
  longint xm [8][8];
  longint exp_a [8][8];
  longint exp_b [8][8];
  int     pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Integer result of a Q12 sum: nearest integer with halves rounded up, then clamped to w bits.
  function automatic longint rnd_sat(input longint a, input int w);
    longint r;
    longint hi;
    r  = (a + 2048) >>> 12;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (r > hi) return hi;
    if (r < -hi - 1) return -hi - 1;
    return r;
  endfunction

  // Reference: T = X * M^T, then Y = M * T, for both width configurations.
  task automatic compute(input bit inv_b);
    longint m [8][8];
    longint ta [8][8];
    longint tb [8][8];
    longint sa;
    longint sb;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        m[i][j] = inv_b ? cm[j*8+i] : cm[i*8+j];
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        sa = 0;
        for (int x = 0; x < 8; x++) sa += m[k][x] * xm[r][x];
        ta[r][k] = rnd_sat(sa, 24);
        tb[r][k] = rnd_sat(sa, 16);
      end
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        sa = 0;
        sb = 0;
        for (int r = 0; r < 8; r++) begin
          sa += m[u][r] * ta[r][v];
          sb += m[u][r] * tb[r][v];
        end
        exp_a[u][v] = rnd_sat(sa, 24);
        exp_b[u][v] = rnd_sat(sb, 16);
      end
  endtask

  task automatic load_coeff();
    for (int i = 0; i < 64; i++) coeff[i*CW +: CW] = CW'(cm[i]);
  endtask

  task automatic set_identity(input int g);
    for (int i = 0; i < 64; i++) cm[i] = (i / 8 == i % 8) ? g : 0;
    load_coeff();
  endtask

  task automatic set_dct();
    real ck;
    for (int k = 0; k < 8; k++)
      for (int x = 0; x < 8; x++) begin
        ck = (k == 0) ? $sqrt(0.125) : 0.5;
        cm[k*8+x] = int'($floor(4096.0 * ck * $cos(real'((2*x+1)*k) * 3.141592653589793 / 16.0) + 0.5));
      end
    load_coeff();
  endtask

  task automatic set_rand_coeff();
    int lim;
    lim = 1 << $urandom_range(8, 15);
    for (int i = 0; i < 64; i++) cm[i] = int'($urandom_range(0, 2*lim - 1)) - lim;
    load_coeff();
  endtask

  task automatic rand_x(input int lim);
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 8; x++) xm[r][x] = longint'(int'($urandom_range(0, 2*lim))) - lim;
  endtask

  // Feed n rows of xm; returns at the negedge after the last accept.
  task automatic send_rows(input int n, input bit inv_b, input bit gaps);
    int budget;
    for (int r = 0; r < n; r++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = {4{$urandom}};
        @(negedge clk);
      end
      in_valid = 1'b1;
      inverse  = (r == 0) ? inv_b : 1'($urandom_range(0, 1));
      for (int x = 0; x < 8; x++) in_data[x*IW +: IW] = IW'(xm[r][x]);
      budget = 0;
      while (bus.in_ready !== 1'b1 && budget < 40) begin
        @(negedge clk);
        budget++;
      end
      check("in_ready_wait", 64'(budget < 40), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = {4{$urandom}};
    inverse  = 1'($urandom_range(0, 1));
    if (n == 8) begin
      check("calc_out_valid", bus.out_valid, 0);
      check("calc_in_ready", bus.in_ready, 0);
    end
  endtask

  // Drain 8 output rows; mode 0: always ready, 1: fixed stall pattern, 2: random.
  task automatic drain(input string tag, input int mode);
    int rows;
    int cyc;
    int pi;
    bit rdy;
    bit stalled;
    logic [191:0] pd;
    logic [191:0] pd16;
    logic pl;
    rows = 0; cyc = 0; pi = 0; stalled = 1'b0; pd = '0; pd16 = '0; pl = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, "_latency"}, bus.out_valid, 1);
    while (rows < 8 && cyc < 200) begin
      if (bus.out_valid === 1'b1) begin
        if (stalled) begin
          check_vec({tag, "_hold_data"}, 192'(bus.out_data), pd);
          check_vec({tag, "_hold_data16"}, 192'(bus16.out_data), pd16);
          check({tag, "_hold_last"}, bus.out_last, 64'(pl));
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       begin rdy = 1'(pat[pi % 6]); pi++; end
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        out_ready = rdy;
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = {4{$urandom}};
        check({tag, "_in_ready_busy"}, bus.in_ready, 0);
        if (rdy) begin
          for (int v = 0; v < 8; v++) begin
            check($sformatf("%s_r%0d_v%0d", tag, rows, v), $signed(bus.out_data[v*24 +: 24]), exp_a[rows][v]);
            check($sformatf("%s_r%0d_v%0d_w16", tag, rows, v), $signed(bus16.out_data[v*16 +: 16]), exp_b[rows][v]);
          end
          check($sformatf("%s_last_r%0d", tag, rows), bus.out_last, 64'(rows == 7));
          rows++;
        end
        stalled = !rdy;
        pd      = 192'(bus.out_data);
        pd16    = 192'(bus16.out_data);
        pl      = bus.out_last;
      end else begin
        check({tag, "_valid_gap"}, bus.out_valid, 1);
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_rows"}, rows, 8);
    if (mode == 0) check({tag, "_burst_cycles"}, cyc, 8);
    check({tag, "_done_valid"}, bus.out_valid, 0);
    check({tag, "_done_last"}, bus.out_last, 0);
    check({tag, "_done_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic run_block(input string tag, input bit inv_b, input int mode, input bit gaps);
    compute(inv_b);
    send_rows(8, inv_b, gaps);
    drain(tag, mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0; clear = 1'b0; inverse = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; coeff = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_last", bus.out_last, 0);
    check_vec("rst_out_data", 192'(bus.out_data), '0);
    check_vec("rst_out_data16", 192'(bus16.out_data), '0);
    reset_n = 1'b1;
    @(negedge clk);

    // identity transform returns the input
    set_identity(4096);
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 8; x++) xm[r][x] = r*8 + x;
    run_block("ident", 1'b0, 0, 1'b0);

    // orthonormal DCT of a flat block
    set_dct();
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 8; x++) xm[r][x] = 100;
    run_block("dct_flat", 1'b0, 0, 1'b1);

    // inverse of a DC-only block, then a forward block
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 8; x++) xm[r][x] = 0;
    xm[0][0] = 800;
    run_block("idct_dc", 1'b1, 0, 1'b0);
    rand_x(255);
    run_block("fwd_after_inv", 1'b0, 0, 1'b0);

    // output backpressure
    rand_x(2000);
    run_block("backpressure", 1'b0, 1, 1'b0);

    // saturation at full-scale inputs
    set_identity(8192);
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 8; x++) xm[r][x] = ((r + x) % 2 == 1) ? -32768 : 32767;
    run_block("saturate", 1'b0, 2, 1'b0);

    // clear after three rows, with a simultaneous row offered
    set_dct();
    rand_x(1000);
    send_rows(3, 1'b1, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = {4{$urandom}};
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check("clr_fill_in_ready", bus.in_ready, 1);
    check("clr_fill_out_valid", bus.out_valid, 0);
    rand_x(1000);
    run_block("after_clear", 1'b0, 0, 1'b0);

    // clear while draining, with a handshake offered the same cycle
    rand_x(3000);
    send_rows(8, 1'b1, 1'b0);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    check("clr_drain_out_valid", bus.out_valid, 0);
    check("clr_drain_out_last", bus.out_last, 0);
    check("clr_drain_in_ready", bus.in_ready, 1);
    rand_x(3000);
    run_block("after_clr_drain", 1'b1, 2, 1'b1);

    // asynchronous reset in the middle of draining
    set_rand_coeff();
    rand_x(5000);
    send_rows(8, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_drain_out_valid", bus.out_valid, 0);
    check("rst_drain_out_last", bus.out_last, 0);
    check("rst_drain_in_ready", bus.in_ready, 1);
    check_vec("rst_drain_out_data", 192'(bus.out_data), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rand_x(5000);
    run_block("after_reset", 1'b0, 0, 1'b0);

    // random coefficients, data, direction and flow control
    for (int b = 0; b < 5; b++) begin
      set_rand_coeff();
      rand_x(32767);
      run_block($sformatf("rand%0d", b), 1'($urandom_range(0, 1)), 2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
